// File: rtl/bcd_countdown_timer_if.sv
// Bus bundle for bcd_countdown_timer.
// Purpose: groups the run-control commands, the load value, the direction
//   select and the timer outputs so the prescaler side and the display side
//   connect through one port.
// Signals:
//   tick, load, start, stop, dir : commands driven by the controller (master)
//   load_value [4*DIGITS-1:0]    : packed BCD preset, digit 0 in bits [3:0]
//   count [4*DIGITS-1:0]         : registered packed BCD value
//   running, done, zero          : status back to the controller
// Modports: master = controller / testbench, slave = timer core.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 4
);
  logic                  tick;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  start;
  logic                  stop;
  logic                  dir;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  done;
  logic                  zero;

  modport master (
    output tick, load, load_value, start, stop, dir,
    input  count, running, done, zero
  );

  modport slave (
    input  tick, load, load_value, start, stop, dir,
    output count, running, done, zero
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit packed-BCD up/down timer with run-control FSM.
// Purpose: steps a DIGITS-wide BCD count by one on each tick honoured in
//   RUN, with digit-to-digit borrow/carry, terminal detection (all zeros
//   counting down, all nines counting up), a one-cycle done pulse and an
//   optional auto-reload from the last loaded value.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_countdown_timer_if.slave (commands in, count/status out)
// Command priority within a cycle: load > stop > start > tick.
module bcd_countdown_timer #(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  bcd_countdown_timer_if.slave         bus
);

  localparam int CW = 4 * DIGITS;
  localparam logic [CW-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] count_q;
  logic [CW-1:0] reload_q;
  logic          running_q;
  logic          done_q;
  // Set when an auto-reload count hit its terminal value; the next honoured
  // tick restores reload_q instead of stepping.
  logic          reload_pend;

  // Any digit above 9 is forced to 9 so the count is always valid BCD.
  function automatic logic [CW-1:0] bcd_clamp(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [CW-1:0] step_val;
  logic          step_term;
  logic          cur_term;

  assign step_val  = bus.dir ? bcd_inc(count_q) : bcd_dec(count_q);
  assign step_term = bus.dir ? (step_val == ALL_NINES) : (step_val == '0);
  // Start is refused when the count already sits on the terminal value for
  // the requested direction.
  assign cur_term  = bus.dir ? (count_q == ALL_NINES) : (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count_q     <= '0;
      reload_q    <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        count_q     <= bcd_clamp(bus.load_value);
        reload_q    <= bcd_clamp(bus.load_value);
        state       <= IDLE;
        running_q   <= 1'b0;
        reload_pend <= 1'b0;
      end else if (bus.stop) begin
        if (state == RUN) begin
          state     <= PAUSE;
          running_q <= 1'b0;
        end
      end else if (bus.start) begin
        if (state != RUN && !cur_term) begin
          state     <= RUN;
          running_q <= 1'b1;
        end
      end else if (bus.tick && state == RUN) begin
        if (reload_pend) begin
          count_q     <= reload_q;
          reload_pend <= 1'b0;
        end else begin
          count_q <= step_val;
          if (step_term) begin
            done_q <= 1'b1;
            if (AUTO_RELOAD) begin
              reload_pend <= 1'b1;
            end else begin
              state     <= DONE;
              running_q <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.zero    = (count_q == '0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (DIGITS=4).
// u_stop runs with AUTO_RELOAD=0 from a vector table; u_auto runs with
// AUTO_RELOAD=1 for the reload sequence. Reset cases are hand-written.
module tb_bcd_countdown_timer;

  logic clk;
  logic rst_n;

  bcd_countdown_timer_if #(.DIGITS(4)) if_s ();
  bcd_countdown_timer_if #(.DIGITS(4)) if_a ();

  bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) u_stop (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s.slave)
  );

  bcd_countdown_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) u_auto (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        load;
    logic [15:0] lv;
    logic        start;
    logic        stop;
    logic        tick;
    logic        dir;
    logic [15:0] e_count;
    logic        e_run;
    logic        e_done;
    logic        e_zero;
  } vec_t;

  vec_t vecs[$];
  int   errors;
  int   checks;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_s(input logic ld, input logic [15:0] lv, input logic st,
                         input logic sp, input logic tk, input logic dr);
    if_s.load = ld; if_s.load_value = lv; if_s.start = st;
    if_s.stop = sp; if_s.tick = tk; if_s.dir = dr;
  endtask

  task automatic drive_a(input logic ld, input logic [15:0] lv, input logic st,
                         input logic sp, input logic tk, input logic dr);
    if_a.load = ld; if_a.load_value = lv; if_a.start = st;
    if_a.stop = sp; if_a.tick = tk; if_a.dir = dr;
  endtask

  // Inputs are applied 1 time unit after a rising edge, sampled by the next
  // rising edge and outputs are read 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [15:0] c, input logic r,
                       input logic d, input logic z);
    chk({tag, "_count"},   if_a.count, c);
    chk({tag, "_running"}, {15'd0, if_a.running}, {15'd0, r});
    chk({tag, "_done"},    {15'd0, if_a.done}, {15'd0, d});
    chk({tag, "_zero"},    {15'd0, if_a.zero}, {15'd0, z});
  endtask

  task automatic chk_s(input string tag, input logic [15:0] c, input logic r,
                       input logic d, input logic z);
    chk({tag, "_count"},   if_s.count, c);
    chk({tag, "_running"}, {15'd0, if_s.running}, {15'd0, r});
    chk({tag, "_done"},    {15'd0, if_s.done}, {15'd0, d});
    chk({tag, "_zero"},    {15'd0, if_s.zero}, {15'd0, z});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    drive_s(0, 16'h0000, 0, 0, 0, 0);
    drive_a(0, 16'h0000, 0, 0, 0, 0);

    //               load lv        st sp tk dir  count     run done zero
    vecs.push_back(vec_t'{1, 16'h0102, 0, 0, 0, 0, 16'h0102, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 1, 0, 0, 0, 16'h0102, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h0101, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h0100, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h0099, 1, 0, 0});
    vecs.push_back(vec_t'{1, 16'h0002, 0, 0, 0, 0, 16'h0002, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 1, 0, 0, 0, 16'h0002, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h0001, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 1, 1});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 0, 1});
    vecs.push_back(vec_t'{1, 16'h0999, 0, 0, 0, 1, 16'h0999, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 1, 0, 0, 1, 16'h0999, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 1, 16'h1000, 1, 0, 0});
    vecs.push_back(vec_t'{1, 16'h9998, 0, 0, 0, 1, 16'h9998, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 1, 0, 0, 1, 16'h9998, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 1, 16'h9999, 0, 1, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 1, 0, 0, 1, 16'h9999, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 1, 0, 0, 0, 16'h9999, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h9998, 1, 0, 0});
    vecs.push_back(vec_t'{1, 16'h0050, 1, 0, 0, 0, 16'h0050, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 1, 0, 0, 0, 16'h0050, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 1, 1, 0, 16'h0050, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h0050, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 1, 0, 0, 0, 16'h0050, 1, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h0049, 1, 0, 0});
    vecs.push_back(vec_t'{1, 16'h00A5, 0, 0, 0, 0, 16'h0095, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 0, 1, 0, 16'h0095, 0, 0, 0});
    vecs.push_back(vec_t'{0, 16'h0000, 0, 1, 0, 0, 16'h0095, 0, 0, 0});

    // Power-on reset values.
    rst_n = 1'b0;
    #12;
    chk_s("reset_s", 16'h0000, 0, 0, 1);
    chk_a("reset_a", 16'h0000, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Table-driven main function on the stopping variant.
    for (int i = 0; i < vecs.size(); i++) begin
      drive_s(vecs[i].load, vecs[i].lv, vecs[i].start, vecs[i].stop, vecs[i].tick, vecs[i].dir);
      cycle();
      chk_s($sformatf("row%0d", i), vecs[i].e_count, vecs[i].e_run, vecs[i].e_done, vecs[i].e_zero);
    end
    drive_s(0, 16'h0000, 0, 0, 0, 0);

    // Auto-reload: period is N+1 ticks, running never drops.
    drive_a(1, 16'h0002, 0, 0, 0, 0); cycle();
    chk_a("ar_load", 16'h0002, 0, 0, 0);
    drive_a(0, 16'h0000, 1, 0, 0, 0); cycle();
    chk_a("ar_start", 16'h0002, 1, 0, 0);
    drive_a(0, 16'h0000, 0, 0, 1, 0); cycle();
    chk_a("ar_t1", 16'h0001, 1, 0, 0);
    cycle();
    chk_a("ar_t2", 16'h0000, 1, 1, 1);
    cycle();
    chk_a("ar_t3", 16'h0002, 1, 0, 0);
    cycle();
    chk_a("ar_t4", 16'h0001, 1, 0, 0);
    drive_a(0, 16'h0000, 0, 0, 0, 0);

    // Asynchronous reset mid-run, mid-cycle.
    drive_s(1, 16'h0005, 0, 0, 0, 0); cycle();
    drive_s(0, 16'h0000, 1, 0, 0, 0); cycle();
    drive_s(0, 16'h0000, 0, 0, 1, 0); cycle();
    chk_s("pre_rst", 16'h0004, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_s("async_rst", 16'h0000, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cycle();
    chk_s("idle_tick_after_rst", 16'h0000, 0, 0, 1);
    drive_s(0, 16'h0000, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised multi-digit BCD up/down timer core for the stopwatch datapath. It is the sequential successor to the fixed 4-bit binary subtractor. It decrements (or increments) a DIGITS-wide packed-BCD value on each qualified tick, with digit-to-digit borrow/carry. A small run-control FSM handles load, start, pause, terminal detection and optional auto-reload. It sits between the tick prescaler and the seven-segment display driver.

## Interface
Parameters:
- DIGITS, 4, number of BCD digits; count width is 4*DIGITS.
- AUTO_RELOAD, 0, 1 = restart from the stored load value after the terminal count instead of stopping.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle count enable from the prescaler; only honoured in RUN.
- load  input  1  load request; highest priority.
- load_value  input  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- start  input  1  start or resume request.
- stop  input  1  pause request.
- dir  input  1  0 = count down, 1 = count up; sampled on each honoured tick.
- count  output  4*DIGITS  current packed BCD value, registered.
- running  output  1  high while the FSM is in RUN.
- done  output  1  one-cycle pulse when the terminal value is reached.
- zero  output  1  high when count is all zeros.

## Operation
- The FSM has four states: IDLE, RUN, PAUSE, DONE. The FSM, count, done and the reload register are all reset asynchronously.
- Command priority in a single cycle is load > stop > start > tick.
- load, from any state: count and the reload register take load_value; the next state is IDLE.
  - Any digit >9 in load_value is clamped to 9 (e.g. 0x00A5 -> 0x0095).
- start:
  - IDLE or PAUSE -> RUN, unless count already equals the terminal value for the current dir. In that case start is ignored.
  - DONE -> RUN, only if count is not terminal for the current dir.
- stop:
  - RUN -> PAUSE; count is held.
  - In IDLE, PAUSE or DONE, stop has no effect.
- tick in RUN, down mode: count = count - 1 in BCD.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - Terminal value is all zeros.
- tick in RUN, up mode: count = count + 1 in BCD.
  - A digit at 9 becomes 0 and carries into the next digit.
  - Terminal value is all nines.
- Terminal reached (the tick whose result equals the terminal value):
  - done pulses on that same edge.
  - AUTO_RELOAD=0: state -> DONE. Later ticks are ignored.
  - AUTO_RELOAD=1: state stays RUN. The next tick loads the reload register, with no arithmetic and no done pulse. The count period is therefore N+1 ticks.
- Ticks outside RUN are ignored. A tick in the same cycle as load, stop or start is ignored.
- zero is a combinational decode of the registered count.
- dir may change while running; each tick uses the current dir. Terminal detection uses the dir of that tick.

## Timing
- Reset values: count = 0, running = 0, done = 0, zero = 1, FSM = IDLE, reload register = 0.
- start -> running high on the next edge. The first count change happens at the first tick sampled while already in RUN.
- tick -> count updates on the same edge (one-cycle latency). There is no combinational path from tick to count.
- done is registered. It is high for exactly one cycle, the cycle in which count first shows the terminal value.
- stop -> running low on the next edge. A tick in the same cycle as stop is lost.
- load during RUN → running low next cycle and count = load_value. A tick in the same cycle is lost.
- Reset asserted mid-run: all outputs go to reset values immediately, without waiting for clk. Release is synchronous to the first clk edge after rst_n rises.
- Back-to-back ticks on every cycle are supported, with one count step per cycle.

## Test plan
- Reset check: assert rst_n=0 mid-cycle with the counter running -> count=0x0000, zero=1, running=0, done=0 immediately; after release, ticks are ignored in IDLE.
- Down borrow (DIGITS=4): load 0x0102, start, 3 ticks -> count 0x0101, 0x0100, 0x0099. running=1 throughout, done=0.
- Terminal stop: load 0x0002, start, 2 ticks -> 0x0001, then 0x0000 with done=1 for one cycle, zero=1, running=0. A further tick leaves count at 0x0000 and done=0.
- Up carry and terminal:
  - dir=1, load 0x0999, start, 1 tick -> 0x1000.
  - load 0x9998, start, 1 tick -> 0x9999 with a done pulse, state DONE.
  - start with dir=1 -> ignored; set dir=0, start -> RUN.
- Auto-reload (AUTO_RELOAD=1): load 0x0002 down, start, 4 ticks -> 0x0001, 0x0000 (done), 0x0002, 0x0001. running stays 1.
- Priority and pause:
  - load 0x0050 with start in the same cycle -> IDLE, count 0x0050.
  - start, then stop with a tick in the same cycle -> PAUSE, count 0x0050.
  - start, tick -> 0x0049.
  - load 0x00A5 -> 0x0095.
